// File: rtl/gen_ser_pkg.sv
// Shared types for the multi-lane serial transmitter.
package gen_ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } gen_ser_state_t;

endpackage

// File: rtl/gen_ser_lane.sv
// One serial lane: parallel load, then shift one bit per clock in the selected order.
module gen_ser_lane #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] w_shifted;

    generate
        if (MSB_FIRST) begin : g_msb
            assign w_shifted = {sreg[WIDTH-2:0], 1'b0};
            assign sout      = sreg[WIDTH-1];
        end else begin : g_lsb
            assign w_shifted = {1'b0, sreg[WIDTH-1:1]};
            assign sout      = sreg[0];
        end
    endgenerate

    // Shift register; load has priority so a back-to-back word replaces the drained one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= w_shifted;
        end else begin
            sreg <= sreg;
        end
    end

endmodule

// File: rtl/gen_ser_tx.sv
// Multi-lane parallel-to-serial transmitter: valid/ready word input, one bit per lane per clock.
module gen_ser_tx
    import gen_ser_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic [LANES-1:0]       ser_out,
    output logic                   ser_frame,
    output logic                   ser_last
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    gen_ser_state_t r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_frame;
    logic           r_last;

    logic           w_at_last;
    logic           w_ready;
    logic           w_accept;
    logic           w_shift;
    logic [CW-1:0]  w_cnt_inc;

    assign w_at_last = (r_state == SHIFT) && (r_cnt == CNT_LAST);
    // Ready depends only on flops and reset, never on in_valid.
    assign w_ready   = rst_n & ((r_state == IDLE) | w_at_last);
    assign w_accept  = in_valid & w_ready;
    assign w_shift   = (r_state == SHIFT) & ~w_accept;
    assign w_cnt_inc = r_cnt + 1'b1;

    assign in_ready  = w_ready;
    assign ser_frame = r_frame;
    assign ser_last  = r_last;

    // Control FSM: bit counter plus registered frame/last markers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_frame <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt  <= '0;
                    r_last <= 1'b0;
                    if (w_accept) begin
                        r_state <= SHIFT;
                        r_frame <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_frame <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt  <= '0;
                        r_last <= 1'b0;
                        if (w_accept) begin
                            r_state <= SHIFT;
                            r_frame <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_frame <= 1'b0;
                        end
                    end else begin
                        r_state <= SHIFT;
                        r_cnt   <= w_cnt_inc;
                        r_frame <= 1'b1;
                        r_last  <= (w_cnt_inc == CNT_LAST);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_frame <= 1'b0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar i = 0; i < LANES; i++) begin : lane
            gen_ser_lane #(
                .WIDTH     (WIDTH),
                .MSB_FIRST (MSB_FIRST)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (w_accept),
                .shift (w_shift),
                .din   (in_data[i*WIDTH +: WIDTH]),
                .sout  (ser_out[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_gen_ser_tx.sv
// Directed self-checking bench: an MSB-first and an LSB-first instance share one stimulus stream.
module tb_gen_ser_tx;

    localparam int LANES = 4;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [31:0]      in_data;

    logic             m_ready, m_frame, m_last;
    logic [3:0]       m_out;
    logic             l_ready, l_frame, l_last;
    logic [3:0]       l_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gen_ser_tx #(.LANES(LANES), .WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (m_ready),
        .in_data   (in_data),
        .ser_out   (m_out),
        .ser_frame (m_frame),
        .ser_last  (m_last)
    );

    gen_ser_tx #(.LANES(LANES), .WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (l_ready),
        .in_data   (in_data),
        .ser_out   (l_out),
        .ser_frame (l_frame),
        .ser_last  (l_last)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bit at position pos of every lane of a 4x8 word.
    function automatic logic [3:0] lane_bits(input logic [31:0] d, input int pos);
        logic [3:0] b;
        for (int i = 0; i < LANES; i++) b[i] = d[i*WIDTH + pos];
        return b;
    endfunction

    // Checks the MSB-first instance during bit k of word d.
    task automatic check_bit(input string tag, input logic [31:0] d, input int k);
        check($sformatf("%s_out%0d", tag, k), {28'd0, m_out}, {28'd0, lane_bits(d, 7 - k)});
        check($sformatf("%s_frame%0d", tag, k), {31'd0, m_frame}, 32'd1);
        check($sformatf("%s_last%0d", tag, k), {31'd0, m_last}, (k == 7) ? 32'd1 : 32'd0);
        check($sformatf("%s_ready%0d", tag, k), {31'd0, m_ready}, (k == 7) ? 32'd1 : 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_frame"}, {31'd0, m_frame}, 32'd0);
        check({tag, "_last"},  {31'd0, m_last},  32'd0);
        check({tag, "_out"},   {28'd0, m_out},   32'd0);
    endtask

    task automatic run_word(input string tag, input logic [31:0] d);
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            check_bit(tag, d, k);
            check($sformatf("%s_lsb%0d", tag, k), {28'd0, l_out}, {28'd0, lane_bits(d, k)});
            step();
        end
        check_idle({tag, "_end"});
        check({tag, "_end_ready"}, {31'd0, m_ready}, 32'd1);
    endtask

    logic [7:0]  seq_a5;
    logic [31:0] w0, w1;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hA5A5A5A5;

        // 1: reset held with valid high
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("rst_ready%0d", c), {31'd0, m_ready}, 32'd0);
            check_idle($sformatf("rst%0d", c));
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rel_ready", {31'd0, m_ready}, 32'd1);
        step();
        check_idle("rel_noaccept");

        // 2: lane0=A5 MSB-first, hand sequence 1,0,1,0,0,1,0,1
        seq_a5 = 8'b1010_0101;
        in_data  = 32'h00FF3CA5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            check($sformatf("a5_bit%0d", k), {31'd0, m_out[0]}, {31'd0, seq_a5[7 - k]});
            check_bit("a5", 32'h00FF3CA5, k);
            step();
        end
        check_idle("a5_end");

        // 3: lane0=01 LSB-first gives 1 then seven 0s
        run_word("w01", 32'h40800201);

        // 4: back-to-back, valid held high
        w0 = 32'h11111111;
        w1 = 32'h22222222;
        in_data  = w0;
        in_valid = 1'b1;
        step();
        in_data = w1;
        for (int c = 0; c < 16; c++) begin
            check_bit("b2b", (c < 8) ? w0 : w1, c % 8);
            step();
            if (c == 7) in_valid = 1'b0;
        end
        check_idle("b2b_end");

        // 5: backpressure, new word offered at cnt=3
        w0 = 32'hC3C3C3C3;
        w1 = 32'h5A5A5A5A;
        in_data  = w0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if (k == 3) begin
                in_valid = 1'b1;
                in_data  = w1;
            end
            check_bit("bp_a", w0, k);
            step();
        end
        in_valid = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            check_bit("bp_b", w1, k);
            step();
        end
        check_idle("bp_end");

        // 6: reset mid-word at cnt=4
        w0 = 32'h0F0F0F0F;
        in_data  = w0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_bit("mid", w0, k);
            if (k < 4) step();
        end
        rst_n = 1'b0;
        step();
        check_idle("mid_rst");
        check("mid_rst_ready", {31'd0, m_ready}, 32'd0);
        rst_n = 1'b1;
        step();
        check_idle("mid_rel");
        run_word("after", 32'h81818181);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
